// File: rtl/mdio_master_ctrl_if.sv
// Command/response port of the Clause-22 MDIO master.
// The requester owns the master modport; the MDIO engine owns the slave modport.
interface mdio_master_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rd;
  logic [4:0]  cmd_phy;
  logic [4:0]  cmd_reg;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_rd, cmd_phy, cmd_reg, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_rd, cmd_phy, cmd_reg, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mdio_master_ctrl.sv
// Generic Clause-22 MDIO master: runs one read or write frame per accepted command
// and returns read data plus a no-response flag. MDC, MDIO and handshake outputs are registered.
module mdio_master_ctrl #(
  parameter int MODULE_CLK  = 50_000_000,
  parameter int MDC_CLK     = 2_500_000,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  mdio_master_ctrl_if.slave  cmd,
  output logic               mdc,
  output logic               mdio_o,
  output logic               mdio_oe,
  input  logic               mdio_i
);

  localparam int DIV   = MODULE_CLK / (2 * MDC_CLK);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_END} state_t;

  state_t            state_q;
  logic [DIV_W-1:0]  div_q;
  logic [5:0]        bit_q;
  logic [31:0]       tx_q;
  logic [15:0]       rx_q;
  logic              rd_q;
  logic              ta_err_q;
  logic              mdc_q;
  logic              mdio_o_q;
  logic              mdio_oe_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [15:0]       rsp_rdata_q;
  logic              rsp_err_q;

  logic [31:0] frame;
  logic        accept;
  logic        half_done;

  // ST, OP, PHYAD, REGAD, TA, DATA; read TA/DATA slots are never driven (oe=0).
  assign frame = {2'b01,
                  cmd.cmd_rd ? 2'b10 : 2'b01,
                  cmd.cmd_phy,
                  cmd.cmd_reg,
                  cmd.cmd_rd ? 2'b11 : 2'b10,
                  cmd.cmd_rd ? 16'hFFFF : cmd.cmd_wdata};
  assign accept    = cmd.cmd_valid && cmd_ready_q;
  assign half_done = (div_q == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_q        <= 1'b0;
      ta_err_q    <= 1'b0;
      mdc_q       <= 1'b0;
      mdio_o_q    <= 1'b1;
      mdio_oe_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q == S_IDLE) begin
        mdc_q <= 1'b0;
        if (accept) begin
          cmd_ready_q <= 1'b0;
          rd_q        <= cmd.cmd_rd;
          tx_q        <= frame;
          div_q       <= '0;
          bit_q       <= '0;
          mdio_oe_q   <= 1'b1;
          if (PREAMBLE_EN) begin
            state_q  <= S_PRE;
            mdio_o_q <= 1'b1;
          end else begin
            state_q  <= S_HDR;
            mdio_o_q <= frame[31];
          end
        end else begin
          cmd_ready_q <= 1'b1;
        end
      end else if (!half_done) begin
        div_q <= div_q + DIV_W'(1);
      end else if (!mdc_q) begin
        // Rising MDC: sample what the PHY is driving.
        div_q <= '0;
        mdc_q <= 1'b1;
        if (state_q == S_TA && bit_q == 6'd1) ta_err_q <= mdio_i;
        if (state_q == S_DATA) rx_q <= {rx_q[14:0], mdio_i};
      end else begin
        // Falling MDC: bit boundary, present the next bit.
        div_q <= '0;
        mdc_q <= 1'b0;
        bit_q <= bit_q + 6'd1;
        case (state_q)
          S_PRE: begin
            if (bit_q == 6'd31) begin
              state_q  <= S_HDR;
              bit_q    <= '0;
              mdio_o_q <= tx_q[31];
            end
          end
          S_HDR: begin
            mdio_o_q <= tx_q[30];
            tx_q     <= {tx_q[30:0], 1'b0};
            if (bit_q == 6'd13) begin
              state_q   <= S_TA;
              bit_q     <= '0;
              mdio_oe_q <= !rd_q;
            end
          end
          S_TA: begin
            mdio_o_q <= tx_q[30];
            tx_q     <= {tx_q[30:0], 1'b0};
            if (bit_q == 6'd1) begin
              state_q <= S_DATA;
              bit_q   <= '0;
            end
          end
          S_DATA: begin
            if (bit_q == 6'd15) begin
              state_q   <= S_END;
              bit_q     <= '0;
              mdio_oe_q <= 1'b0;
              mdio_o_q  <= 1'b1;
            end else begin
              mdio_o_q <= tx_q[30];
              tx_q     <= {tx_q[30:0], 1'b0};
            end
          end
          S_END: begin
            state_q     <= S_IDLE;
            bit_q       <= '0;
            rsp_valid_q <= 1'b1;
            cmd_ready_q <= 1'b1;
            rsp_rdata_q <= rd_q ? rx_q : 16'h0000;
            rsp_err_q   <= rd_q & ta_err_q;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_rdata = rsp_rdata_q;
  assign cmd.rsp_err   = rsp_err_q;
  assign mdc           = mdc_q;
  assign mdio_o        = mdio_o_q;
  assign mdio_oe       = mdio_oe_q;

endmodule

// File: tb/tb_mdio_master_ctrl.sv
// Directed bench for mdio_master_ctrl: one instance with preamble, one without,
// a bench-side PHY driver and a response scoreboard.
module tb_mdio_master_ctrl;
  localparam int DIV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;

  logic        cv    [2];
  logic        crd   [2];
  logic [4:0]  cphy  [2];
  logic [4:0]  creg  [2];
  logic [15:0] cwd   [2];
  logic        rdy   [2];
  logic        rv    [2];
  logic [15:0] rdat  [2];
  logic        rerr  [2];
  logic        mdcw  [2];
  logic        mo    [2];
  logic        moe   [2];
  logic        mi    [2];

  mdio_master_ctrl_if if0 ();
  mdio_master_ctrl_if if1 ();

  assign if0.cmd_valid = cv[0];
  assign if0.cmd_rd    = crd[0];
  assign if0.cmd_phy   = cphy[0];
  assign if0.cmd_reg   = creg[0];
  assign if0.cmd_wdata = cwd[0];
  assign rdy[0]  = if0.cmd_ready;
  assign rv[0]   = if0.rsp_valid;
  assign rdat[0] = if0.rsp_rdata;
  assign rerr[0] = if0.rsp_err;

  assign if1.cmd_valid = cv[1];
  assign if1.cmd_rd    = crd[1];
  assign if1.cmd_phy   = cphy[1];
  assign if1.cmd_reg   = creg[1];
  assign if1.cmd_wdata = cwd[1];
  assign rdy[1]  = if1.cmd_ready;
  assign rv[1]   = if1.rsp_valid;
  assign rdat[1] = if1.rsp_rdata;
  assign rerr[1] = if1.rsp_err;

  mdio_master_ctrl #(.MODULE_CLK(50_000_000), .MDC_CLK(2_500_000), .PREAMBLE_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .cmd(if0),
    .mdc(mdcw[0]), .mdio_o(mo[0]), .mdio_oe(moe[0]), .mdio_i(mi[0])
  );

  mdio_master_ctrl #(.MODULE_CLK(50_000_000), .MDC_CLK(2_500_000), .PREAMBLE_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .cmd(if1),
    .mdc(mdcw[1]), .mdio_o(mo[1]), .mdio_oe(moe[1]), .mdio_i(mi[1])
  );

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command on instance d, play the PHY, and check the whole frame.
  task automatic do_frame(input int d, input bit rd, input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] wdata, input bit respond, input logic [15:0] phy_data,
                          output int waited);
    int pre, nb, exp_lat, rises, mistime, busy_rdy, lat, b;
    logic [31:0]  f32;
    logic [127:0] exp_bits, mask, exp_oe, obs_bits, obs_oe;
    logic prev;
    exp_t e, got;
    pre = (d == 0) ? 32 : 0;
    nb  = pre + 33;
    exp_lat = 1 + nb * 2 * DIV;
    f32 = {2'b01, rd ? 2'b10 : 2'b01, phy, regad, 2'b10, rd ? 16'h0000 : wdata};
    exp_bits = '0; mask = '0; exp_oe = '0; obs_bits = '0; obs_oe = '0;
    for (int k = 0; k < nb; k++) begin
      if (k < pre) exp_bits[k] = 1'b1;
      else if (k < pre + 32) exp_bits[k] = f32[31 - (k - pre)];
      mask[k]   = (k < pre + (rd ? 14 : 32));
      exp_oe[k] = (k < pre + 14) || (!rd && (k < pre + 32));
    end
    e.rdata = rd ? (respond ? phy_data : 16'hFFFF) : 16'h0000;
    e.err   = rd && !respond;

    crd[d] = rd; cphy[d] = phy; creg[d] = regad; cwd[d] = wdata; cv[d] = 1'b1;
    waited = 0;
    while (!rdy[d] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", rdy[d], 1);
    @(posedge clk);
    sb.push_back(e);
    #1 cv[d] = 1'b0;

    prev = 1'b0; lat = 0; rises = 0; mistime = 0; busy_rdy = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (rv[d]) begin
        lat = c;
        break;
      end
      if (rdy[d]) busy_rdy++;
      if (mdcw[d] && !prev) begin
        if (rises < nb) begin
          obs_bits[rises] = mo[d];
          obs_oe[rises]   = moe[d];
        end
        if (c != 1 + DIV + rises * 2 * DIV) mistime++;
        rises++;
      end
      prev = mdcw[d];
      b = (c - 1) / (2 * DIV);
      if (!respond) mi[d] = 1'b1;
      else if (b == pre + 15) mi[d] = 1'b0;
      else if (b >= pre + 16 && b < pre + 32) mi[d] = phy_data[15 - (b - pre - 16)];
      else mi[d] = 1'b1;
    end
    mi[d] = 1'b1;

    chk("rsp_latency", lat, exp_lat);
    chk("mdc_rises", rises, nb);
    chk("mdc_rise_timing", mistime, 0);
    chk("mdio_bits", obs_bits & mask, exp_bits & mask);
    chk("mdio_oe", obs_oe, exp_oe);
    chk("ready_while_busy", busy_rdy, 0);
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("rsp_rdata", rdat[d], got.rdata);
      chk("rsp_err", rerr[d], got.err);
    end else begin
      chk("scoreboard_nonempty", 0, 1);
    end
    $display("txn dut=%0d rd=%0d phy=%02h reg=%02h wdata=%04h lat=%0d rdata=%04h err=%0b",
             d, rd, phy, regad, wdata, lat, rdat[d], rerr[d]);
  endtask

  initial begin
    int w, rv_seen;
    for (int i = 0; i < 2; i++) begin
      cv[i] = 1'b0; crd[i] = 1'b0; cphy[i] = '0; creg[i] = '0; cwd[i] = '0; mi[i] = 1'b1;
    end

    // Reset values
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", rdy[0], 0);
    chk("rst_rsp_valid", rv[0], 0);
    chk("rst_rdata", rdat[0], 16'h0000);
    chk("rst_err", rerr[0], 0);
    chk("rst_mdc", mdcw[0], 0);
    chk("rst_mdio_o", mo[0], 1);
    chk("rst_mdio_oe", moe[0], 0);
    chk("rst_ready_np", rdy[1], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", rdy[0], 1);
    chk("ready_after_rst_np", rdy[1], 1);

    // Preamble write and reads
    do_frame(0, 1'b0, 5'h01, 5'h00, 16'h2100, 1'b0, 16'h0000, w);
    do_frame(0, 1'b1, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h001C, w);
    do_frame(0, 1'b1, 5'h1F, 5'h00, 16'h0000, 1'b0, 16'h0000, w);
    repeat (5) @(negedge clk);
    chk("hold_rdata", rdat[0], 16'hFFFF);
    chk("hold_err", rerr[0], 1);
    chk("idle_mdc", mdcw[0], 0);
    chk("idle_ready", rdy[0], 1);

    // No preamble: back-to-back writes, then a read
    do_frame(1, 1'b0, 5'h03, 5'h04, 16'hBEEF, 1'b0, 16'h0000, w);
    do_frame(1, 1'b0, 5'h05, 5'h1A, 16'h1234, 1'b0, 16'h0000, w);
    chk("b2b_wait", w, 0);
    do_frame(1, 1'b1, 5'h03, 5'h11, 16'h0000, 1'b1, 16'hA5C3, w);

    // Reset at bit 40 of a read abandons the frame
    crd[0] = 1'b1; cphy[0] = 5'h02; creg[0] = 5'h01; cwd[0] = 16'h0000; cv[0] = 1'b1;
    w = 0;
    while (!rdy[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("abort_accept_ready", rdy[0], 1);
    @(posedge clk);
    #1 cv[0] = 1'b0;
    rv_seen = 0;
    for (int c = 1; c <= 801; c++) begin
      @(negedge clk);
      if (rv[0]) rv_seen++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mdc", mdcw[0], 0);
    chk("abort_oe", moe[0], 0);
    chk("abort_mdio_o", mo[0], 1);
    chk("abort_ready", rdy[0], 0);
    repeat (3) begin
      @(negedge clk);
      if (rv[0]) rv_seen++;
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rv[0]) rv_seen++;
    end
    chk("abort_no_rsp", rv_seen, 0);
    $display("txn dut=0 aborted read at bit 40 rsp_seen=%0d", rv_seen);
    do_frame(0, 1'b0, 5'h07, 5'h09, 16'h5A5A, 1'b0, 16'h0000, w);

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
